// File: rtl/fsm_contador_updown_param.sv
// Parametrised modulo-MODULUS up/down counter FSM with enable, clamped parallel load, tc and wrap flags.
// Optional Gray-coded output qg is enabled by defining FSM_CNT_GRAY_EN.
module fsm_contador_updown_param #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef FSM_CNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] qg
`endif
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
      RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_params
    $error("fsm_contador_updown_param: illegal WIDTH/MODULUS/RST_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] state_q, state_d;
  logic             wrap_q, wrap_d;

  // State register: the count value is the FSM state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_Q;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: ld beats en; loads outside the range clamp to the top state.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    if (ld) begin
      state_d = ({1'b0, d} < MOD_EXT) ? d : MAX_Q;
    end else if (en) begin
      if (dir) begin
        wrap_d  = (state_q == '0);
        state_d = wrap_d ? MAX_Q : state_q - ONE_Q;
      end else begin
        wrap_d  = (state_q == MAX_Q);
        state_d = wrap_d ? '0 : state_q + ONE_Q;
      end
    end
  end

  // Output logic.
  always_comb begin
    q    = state_q;
    wrap = wrap_q;
    tc   = en & (dir ? (state_q == '0) : (state_q == MAX_Q));
  end

`ifdef FSM_CNT_GRAY_EN
  logic [WIDTH-1:0] qg_q, qg_d;

  // Gray code is registered from the next state so it lines up with q on the same edge.
  always_comb qg_d = state_d ^ (state_d >> 1);

  always_ff @(posedge clk) begin
    if (!rst) qg_q <= RST_Q ^ (RST_Q >> 1);
    else      qg_q <= qg_d;
  end

  assign qg = qg_q;
`endif

endmodule

// File: tb/tb_fsm_contador_updown_param.sv
// Randomised self-checking bench for fsm_contador_updown_param (WIDTH=4, MODULUS=10, RST_VAL=0).
// With FSM_CNT_GRAY_EN defined, a second WIDTH=3/MODULUS=8 instance checks the Gray output.
module tb_fsm_contador_updown_param;
  localparam int W = 4;
  localparam int M = 10;
  localparam int R = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b0, en = 1'b0, dir = 1'b0, ld = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         tc, wrap;
`ifdef FSM_CNT_GRAY_EN
  logic [W-1:0] qg;
  logic         g_rst = 1'b0, g_en = 1'b0;
  logic [2:0]   g_q, g_qg, g_d = '0;
  logic         g_tc, g_wrap;
`endif

  int errors = 0;
  int checks = 0;
  int mq = R;      // reference count value
  bit mw = 1'b0;   // reference wrap flag
  bit exp_tc, obs_tc;

  always #5 clk = ~clk;

  fsm_contador_updown_param #(.WIDTH(W), .MODULUS(M), .RST_VAL(R)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .d(d),
    .q(q), .tc(tc), .wrap(wrap)
`ifdef FSM_CNT_GRAY_EN
    , .qg(qg)
`endif
  );

`ifdef FSM_CNT_GRAY_EN
  fsm_contador_updown_param #(.WIDTH(3), .MODULUS(8), .RST_VAL(0)) dut_g (
    .clk(clk), .rst(g_rst), .en(g_en), .dir(1'b0), .ld(1'b0), .d(g_d),
    .q(g_q), .tc(g_tc), .wrap(g_wrap), .qg(g_qg)
  );
`endif

  // Apply inputs at negedge, capture tc before the edge, advance the model at the edge.
  task automatic drive(input bit r, input bit e, input bit dr, input bit l, input int dv);
    @(negedge clk);
    rst = r; en = e; dir = dr; ld = l; d = W'(dv);
    #1;
    exp_tc = e && (dr ? (mq == 0) : (mq == M - 1));
    obs_tc = tc;
    @(posedge clk);
    if (!r) begin
      mq = R; mw = 1'b0;
    end else if (l) begin
      mq = (dv < M) ? dv : M - 1; mw = 1'b0;
    end else if (e) begin
      mw = dr ? (mq == 0) : (mq == M - 1);
      mq = dr ? (mq + M - 1) % M : (mq + 1) % M;
    end else begin
      mw = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) drive(0, 1, 0, 1, 5);
    checks++; if (q !== W'(R)) begin errors++; $display("FAIL reset_q: got %0d want %0d", q, R); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    @(negedge clk); rst = 1'b1; en = 1'b0; ld = 1'b0; #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_en0: got %b want 0", tc); end
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 0, 0, 0);
      checks++; if (obs_tc !== exp_tc) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, obs_tc, exp_tc); end
      checks++; if (q !== W'(mq)) begin errors++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, mq); end
      checks++; if (wrap !== mw) begin errors++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, mw); end
    end
    checks++; if (q !== W'(2)) begin errors++; $display("FAIL up_end: got %0d want 2", q); end
  endtask

  task automatic test_down_wrap();
    drive(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0);
      checks++; if (obs_tc !== exp_tc) begin errors++; $display("FAIL dn_tc[%0d]: got %b want %b", i, obs_tc, exp_tc); end
      checks++; if (q !== W'(mq)) begin errors++; $display("FAIL dn_q[%0d]: got %0d want %0d", i, q, mq); end
      checks++; if (wrap !== mw) begin errors++; $display("FAIL dn_wrap[%0d]: got %b want %b", i, wrap, mw); end
    end
    checks++; if (q !== W'(8)) begin errors++; $display("FAIL dn_end: got %0d want 8", q); end
  endtask

  task automatic test_load();
    int vals[6];
    vals = '{7, 13, 9, 10, 15, 0};
    foreach (vals[i]) begin
      drive(1, 1, i % 2, 1, vals[i]);
      checks++; if (q !== W'(mq)) begin errors++; $display("FAIL load_q[d=%0d]: got %0d want %0d", vals[i], q, mq); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_wrap[d=%0d]: got %b want 0", vals[i], wrap); end
    end
    drive(1, 1, 0, 1, 9);
    drive(1, 1, 0, 1, 13);
    checks++; if (q !== W'(9)) begin errors++; $display("FAIL load_clamp: got %0d want 9", q); end
    drive(0, 1, 0, 1, 7);
    checks++; if (q !== W'(R)) begin errors++; $display("FAIL load_rst_prio: got %0d want %0d", q, R); end
  endtask

  task automatic test_hold_dir();
    drive(1, 0, 0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, i % 2, 0, 0);
      checks++; if (q !== W'(4)) begin errors++; $display("FAIL hold_q[%0d]: got %0d want 4", i, q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %b want 0", i, wrap); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, i % 2, 0, 0);
      checks++; if (q !== W'((i % 2) ? 4 : 5)) begin errors++; $display("FAIL dir_toggle[%0d]: got %0d want %0d", i, q, (i % 2) ? 4 : 5); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 9) == 0, $urandom_range(0, 15));
      checks++; if (obs_tc !== exp_tc) begin errors++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, obs_tc, exp_tc); end
      checks++; if (q !== W'(mq)) begin errors++; $display("FAIL rnd_q[%0d]: got %0d want %0d", i, q, mq); end
      checks++; if (wrap !== mw) begin errors++; $display("FAIL rnd_wrap[%0d]: got %b want %b", i, wrap, mw); end
`ifdef FSM_CNT_GRAY_EN
      checks++; if (qg !== W'(mq ^ (mq >> 1))) begin errors++; $display("FAIL rnd_qg[%0d]: got %0d want %0d", i, qg, mq ^ (mq >> 1)); end
`endif
    end
  endtask

`ifdef FSM_CNT_GRAY_EN
  task automatic test_gray();
    int exp_g[9];
    logic [2:0] prev;
    exp_g = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    @(negedge clk); g_rst = 1'b0; g_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (g_qg !== 3'(exp_g[0])) begin errors++; $display("FAIL gray[0]: got %0d want %0d", g_qg, exp_g[0]); end
    prev = g_qg;
    @(negedge clk); g_rst = 1'b1;
    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
      checks++; if (g_qg !== 3'(exp_g[i])) begin errors++; $display("FAIL gray[%0d]: got %0d want %0d", i, g_qg, exp_g[i]); end
      checks++; if ($countones(g_qg ^ prev) != 1) begin errors++; $display("FAIL gray_dist[%0d]: got %0d->%0d want 1-bit change", i, prev, g_qg); end
      prev = g_qg;
    end
    @(negedge clk); g_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_dir();
    test_random();
`ifdef FSM_CNT_GRAY_EN
    test_gray();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
